// File: rtl/ysyx_24080006_csr_unit_if.sv
// ysyx_24080006_csr_unit_if
//   Commit-side bus between the core (EXU/WBU) and the machine-mode CSR unit.
//   master: core side, drives CSR ops, trap/mret commits, instret and the timer request.
//   slave : CSR unit, returns read data, illegal flag, interrupt pending and trap/return targets.
//   Signals:
//     csr_en, csr_op[1:0], csr_addr[11:0], csr_wdata[31:0]  CSR instruction commit
//     csr_rdata[31:0], csr_illegal                          CSR read result / illegal access
//     trap_valid, trap_irq, trap_cause[4:0], trap_pc, trap_tval  trap commit
//     mret, instret, irq_timer                              return, retire, timer request
//     irq_pending, epc[31:0], tvec[31:0]                    to IFU / interrupt logic
interface ysyx_24080006_csr_unit_if;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_valid;
   logic        trap_irq;
   logic [4:0]  trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;
   logic        mret;
   logic        instret;
   logic        irq_timer;
   logic        irq_pending;
   logic [31:0] epc;
   logic [31:0] tvec;

   modport master (
      output csr_en, csr_op, csr_addr, csr_wdata,
      output trap_valid, trap_irq, trap_cause, trap_pc, trap_tval,
      output mret, instret, irq_timer,
      input  csr_rdata, csr_illegal, irq_pending, epc, tvec
   );

   modport slave (
      input  csr_en, csr_op, csr_addr, csr_wdata,
      input  trap_valid, trap_irq, trap_cause, trap_pc, trap_tval,
      input  mret, instret, irq_timer,
      output csr_rdata, csr_illegal, irq_pending, epc, tvec
   );
endinterface

// File: rtl/ysyx_24080006_csr_unit.sv
// ysyx_24080006_csr_unit
//   Machine-mode CSR file: mstatus (MIE/MPIE), mie (MTIE), mtvec, mscratch, mepc, mcause,
//   mtval, mip (MTIP), minstret[h], optional mcycle[h], mvendorid, marchid.
//   Handles CSR READ/WRITE/SET/CLEAR, trap entry and mret in a single cycle.
//   Ports:
//     clock  : clock
//     reset  : synchronous, active-high reset
//     bus    : ysyx_24080006_csr_unit_if.slave (CSR op, trap/mret commit, instret, timer,
//              csr_rdata/csr_illegal, irq_pending, epc, tvec)
//   Parameters: CNT_W (33..64 counter width), MTVEC_RESET, MVENDORID, MARCHID.
//   Optional feature: define YSYX_24080006_MCYCLE_EN to implement mcycle/mcycleh.
module ysyx_24080006_csr_unit #(
   parameter int unsigned CNT_W       = 64,
   parameter logic [31:0] MTVEC_RESET = 32'h0,
   parameter logic [31:0] MVENDORID   = 32'h7973_7978,
   parameter logic [31:0] MARCHID     = 32'd24080006
) (
   input logic clock,
   input logic reset,
   ysyx_24080006_csr_unit_if.slave bus
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 12;

   localparam logic [ADDR_W-1:0] A_MSTATUS   = 12'h300;
   localparam logic [ADDR_W-1:0] A_MIE       = 12'h304;
   localparam logic [ADDR_W-1:0] A_MTVEC     = 12'h305;
   localparam logic [ADDR_W-1:0] A_MSCRATCH  = 12'h340;
   localparam logic [ADDR_W-1:0] A_MEPC      = 12'h341;
   localparam logic [ADDR_W-1:0] A_MCAUSE    = 12'h342;
   localparam logic [ADDR_W-1:0] A_MTVAL     = 12'h343;
   localparam logic [ADDR_W-1:0] A_MIP       = 12'h344;
   localparam logic [ADDR_W-1:0] A_MCYCLE    = 12'hB00;
   localparam logic [ADDR_W-1:0] A_MINSTRET  = 12'hB02;
   localparam logic [ADDR_W-1:0] A_MCYCLEH   = 12'hB80;
   localparam logic [ADDR_W-1:0] A_MINSTRETH = 12'hB82;
   localparam logic [ADDR_W-1:0] A_MVENDORID = 12'hF11;
   localparam logic [ADDR_W-1:0] A_MARCHID   = 12'hF12;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_SET   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h3;

   // architectural state
   logic            st_mie;
   logic            st_mpie;
   logic            mtie;
   logic            mtip;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mscratch;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;
   logic [XLEN-1:0] mtval;
   logic [CNT_W-1:0] minstret;
   logic            irq_pending_q;

   // counters zero-extended to 64 bits so high-half reads/writes work for any CNT_W
   logic [63:0] minstret64;
   assign minstret64 = 64'(minstret);

`ifdef YSYX_24080006_MCYCLE_EN
   logic [CNT_W-1:0] mcycle;
   logic [63:0]      mcycle64;
   assign mcycle64 = 64'(mcycle);
`endif

   logic [XLEN-1:0] rdata;
   logic            addr_hit;
   logic            addr_ro;
   logic            illegal;
   logic [XLEN-1:0] wval;
   logic            wr_en;

   // read mux and address decode (pre-write values)
   always_comb begin
      rdata    = '0;
      addr_hit = 1'b1;
      addr_ro  = 1'b0;
      case (bus.csr_addr)
         A_MSTATUS:   rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
         A_MIE:       rdata = {24'b0, mtie, 7'b0};
         A_MTVEC:     rdata = mtvec;
         A_MSCRATCH:  rdata = mscratch;
         A_MEPC:      rdata = mepc;
         A_MCAUSE:    rdata = mcause;
         A_MTVAL:     rdata = mtval;
         A_MIP:       rdata = {24'b0, mtip, 7'b0};
         A_MINSTRET:  rdata = minstret64[31:0];
         A_MINSTRETH: rdata = minstret64[63:32];
`ifdef YSYX_24080006_MCYCLE_EN
         A_MCYCLE:    rdata = mcycle64[31:0];
         A_MCYCLEH:   rdata = mcycle64[63:32];
`else
         A_MCYCLE:    rdata = '0;
         A_MCYCLEH:   rdata = '0;
`endif
         A_MVENDORID: begin
            rdata   = MVENDORID;
            addr_ro = 1'b1;
         end
         A_MARCHID: begin
            rdata   = MARCHID;
            addr_ro = 1'b1;
         end
         default:     addr_hit = 1'b0;
      endcase
   end

   assign illegal = bus.csr_en & (~addr_hit | (addr_ro & (bus.csr_op != OP_READ)));

   // new value for the addressed CSR
   always_comb begin
      wval = rdata;
      case (bus.csr_op)
         OP_WRITE: wval = bus.csr_wdata;
         OP_SET:   wval = rdata | bus.csr_wdata;
         OP_CLEAR: wval = rdata & ~bus.csr_wdata;
         default:  wval = rdata;
      endcase
   end

   // a CSR write only lands when no trap or mret commits the same cycle
   assign wr_en = bus.csr_en & ~illegal & (bus.csr_op != OP_READ)
                  & ~bus.trap_valid & ~bus.mret;

   logic wr_instret_lo;
   logic wr_instret_hi;
   assign wr_instret_lo = wr_en & (bus.csr_addr == A_MINSTRET);
   assign wr_instret_hi = wr_en & (bus.csr_addr == A_MINSTRETH);

   // trap / mret / CSR write state update
   always_ff @(posedge clock) begin
      if (reset) begin
         st_mie        <= 1'b0;
         st_mpie       <= 1'b0;
         mtie          <= 1'b0;
         mtip          <= 1'b0;
         mtvec         <= MTVEC_RESET & ALIGN_MASK;
         mscratch      <= '0;
         mepc          <= '0;
         mcause        <= '0;
         mtval         <= '0;
         irq_pending_q <= 1'b0;
      end else begin
         mtip          <= bus.irq_timer;
         irq_pending_q <= st_mie & mtie & mtip;
         if (bus.trap_valid) begin
            mepc    <= bus.trap_pc & ALIGN_MASK;
            mcause  <= {bus.trap_irq, 26'b0, bus.trap_cause};
            mtval   <= bus.trap_irq ? '0 : bus.trap_tval;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
         end else if (bus.mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end else if (wr_en) begin
            case (bus.csr_addr)
               A_MSTATUS: begin
                  st_mie  <= wval[3];
                  st_mpie <= wval[7];
               end
               A_MIE:      mtie     <= wval[7];
               A_MTVEC:    mtvec    <= wval & ALIGN_MASK;
               A_MSCRATCH: mscratch <= wval;
               A_MEPC:     mepc     <= wval & ALIGN_MASK;
               A_MCAUSE:   mcause   <= wval;
               A_MTVAL:    mtval    <= wval;
               default:    ;
            endcase
         end
      end
   end

   // minstret: CSR write beats the retire increment
   always_ff @(posedge clock) begin
      if (reset) begin
         minstret <= '0;
      end else if (wr_instret_lo) begin
         minstret <= CNT_W'({minstret64[63:32], wval});
      end else if (wr_instret_hi) begin
         minstret <= CNT_W'({wval, minstret64[31:0]});
      end else if (bus.instret) begin
         minstret <= minstret + CNT_W'(1);
      end
   end

`ifdef YSYX_24080006_MCYCLE_EN
   logic wr_cycle_lo;
   logic wr_cycle_hi;
   assign wr_cycle_lo = wr_en & (bus.csr_addr == A_MCYCLE);
   assign wr_cycle_hi = wr_en & (bus.csr_addr == A_MCYCLEH);

   // mcycle: free-running, CSR write beats the increment
   always_ff @(posedge clock) begin
      if (reset) begin
         mcycle <= '0;
      end else if (wr_cycle_lo) begin
         mcycle <= CNT_W'({mcycle64[63:32], wval});
      end else if (wr_cycle_hi) begin
         mcycle <= CNT_W'({wval, mcycle64[31:0]});
      end else begin
         mcycle <= mcycle + CNT_W'(1);
      end
   end
`endif

   assign bus.csr_rdata   = rdata;
   assign bus.csr_illegal = illegal;
   assign bus.irq_pending = irq_pending_q;
   assign bus.epc         = mepc;
   assign bus.tvec        = mtvec;

endmodule

// File: tb/tb_ysyx_24080006_csr_unit.sv
// tb_ysyx_24080006_csr_unit
//   Directed bench for the machine-mode CSR unit (CNT_W=33, MTVEC_RESET=0x80000001).
//   Stimulus pushes expected responses into a queue; a negedge monitor pops and compares
//   whenever the stimulus marks a cycle as observable.
module tb_ysyx_24080006_csr_unit;

   logic clock;
   logic reset;
   logic probe;

   ysyx_24080006_csr_unit_if ifc ();

   ysyx_24080006_csr_unit #(
      .CNT_W       (33),
      .MTVEC_RESET (32'h8000_0001)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        do_csr;
      logic        do_side;
      logic [11:0] addr;
      logic [31:0] rdata;
      logic        illegal;
      logic        irq;
      logic [31:0] epc;
      logic [31:0] tvec;
   } exp_t;

   exp_t q[$];
   int   n_pass   = 0;
   int   n_checks = 0;

   task automatic chk(input string name, input logic [11:0] a,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s addr=%03h got=%08h expected=%08h t=%0t", name, a, act, exp, $time);
   endtask

   // monitor: compares on every observable cycle
   always @(negedge clock) begin
      if (probe) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty t=%0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.do_csr) begin
               chk("rdata", e.addr, ifc.csr_rdata, e.rdata);
               chk("illegal", e.addr, 32'(ifc.csr_illegal), 32'(e.illegal));
            end
            if (e.do_side) begin
               chk("irq_pending", e.addr, 32'(ifc.irq_pending), 32'(e.irq));
               chk("epc", e.addr, ifc.epc, e.epc);
               chk("tvec", e.addr, ifc.tvec, e.tvec);
               chk("illegal_idle", e.addr, 32'(ifc.csr_illegal), 32'(e.illegal));
            end
         end
      end
   end

   task automatic clear_inputs();
      ifc.csr_en     = 1'b0;
      ifc.csr_op     = 2'd0;
      ifc.csr_addr   = 12'h0;
      ifc.csr_wdata  = 32'h0;
      ifc.trap_valid = 1'b0;
      ifc.trap_irq   = 1'b0;
      ifc.trap_cause = 5'd0;
      ifc.trap_pc    = 32'h0;
      ifc.trap_tval  = 32'h0;
      ifc.mret       = 1'b0;
      ifc.instret    = 1'b0;
      probe          = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      clear_inputs();
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_r, input logic exp_ill);
      exp_t e;
      e = '{do_csr: 1'b1, do_side: 1'b0, addr: a, rdata: exp_r, illegal: exp_ill,
            irq: 1'b0, epc: 32'h0, tvec: 32'h0};
      q.push_back(e);
      ifc.csr_en    = 1'b1;
      ifc.csr_op    = op;
      ifc.csr_addr  = a;
      ifc.csr_wdata = wd;
      probe         = 1'b1;
      tick();
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp_r);
      csr(2'd0, a, 32'h0, exp_r, 1'b0);
   endtask

   task automatic side(input logic irq, input logic [31:0] ep, input logic [31:0] tv);
      exp_t e;
      e = '{do_csr: 1'b0, do_side: 1'b1, addr: 12'h0, rdata: 32'h0, illegal: 1'b0,
            irq: irq, epc: ep, tvec: tv};
      q.push_back(e);
      probe = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin
      clear_inputs();
      ifc.irq_timer = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // reset state
      side(1'b0, 32'h0, 32'h8000_0000);
      rd(12'h300, 32'h0000_1800);
      rd(12'h305, 32'h8000_0000);
      rd(12'hF11, 32'h7973_7978);
      rd(12'hF12, 32'd24080006);
      rd(12'h344, 32'h0);
`ifndef YSYX_24080006_MCYCLE_EN
      rd(12'hB00, 32'h0);
      csr(2'd1, 12'hB00, 32'h5, 32'h0, 1'b0);
      rd(12'hB80, 32'h0);
`endif

      // enable timer interrupt; pending shows two cycles after the request
      csr(2'd1, 12'h300, 32'h88, 32'h0000_1800, 1'b0);
      csr(2'd2, 12'h304, 32'h80, 32'h0, 1'b0);
      ifc.irq_timer = 1'b1;
      side(1'b0, 32'h0, 32'h8000_0000);
      side(1'b0, 32'h0, 32'h8000_0000);
      side(1'b1, 32'h0, 32'h8000_0000);
      rd(12'h344, 32'h80);
      rd(12'h304, 32'h80);
      rd(12'h300, 32'h0000_1888);

      // mtvec alignment
      csr(2'd1, 12'h305, 32'h1234_5677, 32'h8000_0000, 1'b0);
      rd(12'h305, 32'h1234_5674);
      side(1'b1, 32'h0, 32'h1234_5674);

      // exception trap then mret
      ifc.trap_valid = 1'b1;
      ifc.trap_irq   = 1'b0;
      ifc.trap_cause = 5'd11;
      ifc.trap_pc    = 32'h8000_0102;
      ifc.trap_tval  = 32'h55;
      tick();
      rd(12'h341, 32'h8000_0100);
      rd(12'h342, 32'h0000_000B);
      rd(12'h343, 32'h55);
      rd(12'h300, 32'h0000_1880);
      side(1'b0, 32'h8000_0100, 32'h1234_5674);
      ifc.mret = 1'b1;
      tick();
      rd(12'h300, 32'h0000_1888);

      // trap + mret + write in one cycle: only the trap lands
      ifc.trap_valid = 1'b1;
      ifc.trap_irq   = 1'b1;
      ifc.trap_cause = 5'd7;
      ifc.trap_pc    = 32'h0000_0100;
      ifc.trap_tval  = 32'hDEAD_BEEF;
      ifc.mret       = 1'b1;
      csr(2'd1, 12'h340, 32'h1, 32'h0, 1'b0);
      rd(12'h340, 32'h0);
      rd(12'h342, 32'h8000_0007);
      rd(12'h343, 32'h0);
      rd(12'h341, 32'h0000_0100);
      rd(12'h300, 32'h0000_1880);

      // mepc alignment, SET/CLEAR, mstatus write mask
      csr(2'd1, 12'h341, 32'h3, 32'h0000_0100, 1'b0);
      rd(12'h341, 32'h0);
      csr(2'd2, 12'h300, 32'h8, 32'h0000_1880, 1'b0);
      rd(12'h300, 32'h0000_1888);
      csr(2'd3, 12'h300, 32'h80, 32'h0000_1888, 1'b0);
      rd(12'h300, 32'h0000_1808);
      csr(2'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1808, 1'b0);
      rd(12'h300, 32'h0000_1888);

      // minstret, 33-bit wrap and write-wins
      csr(2'd1, 12'hB82, 32'h1, 32'h0, 1'b0);
      csr(2'd1, 12'hB02, 32'hFFFF_FFFF, 32'h0, 1'b0);
      rd(12'hB82, 32'h1);
      rd(12'hB02, 32'hFFFF_FFFF);
      ifc.instret = 1'b1;
      tick();
      rd(12'hB02, 32'h0);
      rd(12'hB82, 32'h0);
      ifc.instret = 1'b1;
      csr(2'd1, 12'hB02, 32'h5, 32'h0, 1'b0);
      rd(12'hB02, 32'h5);
      csr(2'd1, 12'hB82, 32'hFFFF_FFFF, 32'h0, 1'b0);
      rd(12'hB82, 32'h1);
      ifc.instret = 1'b1;
      rd(12'hB02, 32'h5);
      rd(12'hB02, 32'h6);

      // illegal and read-only accesses
      csr(2'd1, 12'hF11, 32'h0, 32'h7973_7978, 1'b1);
      rd(12'hF11, 32'h7973_7978);
      csr(2'd2, 12'hF12, 32'h1, 32'd24080006, 1'b1);
      csr(2'd0, 12'h7C0, 32'h0, 32'h0, 1'b1);
      csr(2'd1, 12'h344, 32'h0, 32'h80, 1'b0);
      rd(12'h344, 32'h80);

      // reset discards same-cycle trap, write and instret
      ifc.trap_valid = 1'b1;
      ifc.trap_cause = 5'd2;
      ifc.trap_pc    = 32'h40;
      ifc.instret    = 1'b1;
      ifc.csr_en     = 1'b1;
      ifc.csr_op     = 2'd1;
      ifc.csr_addr   = 12'h340;
      ifc.csr_wdata  = 32'hAA;
      ifc.irq_timer  = 1'b0;
      reset          = 1'b1;
      tick();
      reset = 1'b0;
      side(1'b0, 32'h0, 32'h8000_0000);
      rd(12'h300, 32'h0000_1800);
      rd(12'h340, 32'h0);
      rd(12'h342, 32'h0);
      rd(12'hB02, 32'h0);
      rd(12'h304, 32'h0);

      repeat (2) @(posedge clock);
      #1;
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
